bp_cfg_table_streamer: RTL



---
 rtl/bp_common_cfg_pkg.sv | 29 ++
 rtl/bp_cfg_table_mem.sv | 42 ++++
 rtl/bp_cfg_table_streamer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/bp_common_cfg_pkg.sv
// Shared types and constants for the runtime processor-config table streamer.
package bp_common_cfg_pkg;

  typedef enum logic [1:0] {
    e_cfg_idle,
    e_cfg_stream,
    e_cfg_commit,
    e_cfg_err
  } bp_cfg_stream_state_e;

  localparam int unsigned bp_cfg_inv_id_gp = 0;

  // Record layout: field index order as streamed to the per-tile config registers.
  typedef enum logic [4:0] {
    e_cfg_f_freeze,      e_cfg_f_core_id,     e_cfg_f_did,         e_cfg_f_cord,
    e_cfg_f_host_did,    e_cfg_f_icache_mode, e_cfg_f_dcache_mode, e_cfg_f_cce_mode,
    e_cfg_f_npc_lo,      e_cfg_f_npc_hi,      e_cfg_f_domain_mask, e_cfg_f_sac_x,
    e_cfg_f_sac_y,       e_cfg_f_irf_base,    e_cfg_f_fpu_en,      e_cfg_f_hio_mask,
    e_cfg_f_ptag_base,   e_cfg_f_clint_base,  e_cfg_f_plic_base,   e_cfg_f_l2_mode,
    e_cfg_f_coh_mode,    e_cfg_f_mem_offset,  e_cfg_f_mem_limit,   e_cfg_f_boot_lo,
    e_cfg_f_boot_hi,     e_cfg_f_rsvd_25,     e_cfg_f_rsvd_26,     e_cfg_f_rsvd_27,
    e_cfg_f_rsvd_28,     e_cfg_f_rsvd_29,     e_cfg_f_rsvd_30,     e_cfg_f_rsvd_31
  } bp_cfg_field_e;

  function automatic int unsigned bp_safe_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_cfg_table_mem.sv
// Config record storage: flop array, one synchronous write port, one combinational read port.
module bp_cfg_table_mem
  import bp_common_cfg_pkg::*;
#(
  parameter int unsigned num_cfgs_p    = 16,
  parameter int unsigned fields_p      = 32,
  parameter int unsigned field_width_p = 16,
  parameter int unsigned lg_cfgs_lp    = bp_safe_clog2(num_cfgs_p),
  parameter int unsigned lg_fields_lp  = bp_safe_clog2(fields_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     w_v_i,
  input  logic [lg_cfgs_lp-1:0]    w_cfg_i,
  input  logic [lg_fields_lp-1:0]  w_field_i,
  input  logic [field_width_p-1:0] w_data_i,
  input  logic [lg_cfgs_lp-1:0]    r_cfg_i,
  input  logic [lg_fields_lp-1:0]  r_field_i,
  output logic [field_width_p-1:0] r_data_o
);

  logic [field_width_p-1:0] mem_q [num_cfgs_p][fields_p];
  logic [field_width_p-1:0] mem_d [num_cfgs_p][fields_p];

  always_comb begin
    mem_d = mem_q;
    if (w_v_i) begin
      mem_d[w_cfg_i][w_field_i] = w_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_q <= '{default: '{default: '0}};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign r_data_o = mem_q[r_cfg_i][r_field_i];

endmodule

// File: rtl/bp_cfg_table_streamer.sv
// Programmable config table that streams one selected record to a set of consumer channels.
module bp_cfg_table_streamer
  import bp_common_cfg_pkg::*;
#(
  parameter int unsigned num_cfgs_p    = 16,
  parameter int unsigned fields_p      = 32,
  parameter int unsigned field_width_p = 16,
  parameter int unsigned channels_p    = 4,
  localparam int unsigned lg_cfgs_lp   = bp_safe_clog2(num_cfgs_p),
  localparam int unsigned lg_fields_lp = bp_safe_clog2(fields_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     tbl_w_v_i,
  input  logic [lg_cfgs_lp-1:0]    tbl_w_cfg_i,
  input  logic [lg_fields_lp-1:0]  tbl_w_field_i,
  input  logic [field_width_p-1:0] tbl_w_data_i,
  output logic                     tbl_w_ready_o,
  input  logic                     req_v_i,
  input  logic [lg_cfgs_lp-1:0]    req_id_i,
  input  logic [channels_p-1:0]    req_mask_i,
  output logic                     req_ready_o,
  output logic [channels_p-1:0]    cfg_v_o,
  output logic [lg_fields_lp-1:0]  cfg_field_o,
  output logic [field_width_p-1:0] cfg_data_o,
  input  logic [channels_p-1:0]    cfg_ready_i,
  output logic [channels_p-1:0]    commit_v_o,
  output logic                     err_o
);

  bp_cfg_stream_state_e     state_q, state_d;
  logic [lg_cfgs_lp-1:0]    id_q, id_d;
  logic [channels_p-1:0]    mask_q, mask_d;
  logic [lg_fields_lp-1:0]  field_q, field_d;
  logic                     tbl_we;
  logic                     req_bad;
  logic [field_width_p-1:0] rd_data;

  // Writes are only honoured while idle; reserved and out-of-range targets are dropped.
  assign tbl_we = (state_q == e_cfg_idle) && tbl_w_v_i
               && (32'(tbl_w_cfg_i) != bp_cfg_inv_id_gp)
               && (32'(tbl_w_cfg_i) < num_cfgs_p)
               && (32'(tbl_w_field_i) < fields_p);

  assign req_bad = (32'(req_id_i) == bp_cfg_inv_id_gp)
                || (32'(req_id_i) >= num_cfgs_p)
                || (req_mask_i == '0);

  bp_cfg_table_mem #(
    .num_cfgs_p    (num_cfgs_p),
    .fields_p      (fields_p),
    .field_width_p (field_width_p),
    .lg_cfgs_lp    (lg_cfgs_lp),
    .lg_fields_lp  (lg_fields_lp)
  ) u_mem (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .w_v_i     (tbl_we),
    .w_cfg_i   (tbl_w_cfg_i),
    .w_field_i (tbl_w_field_i),
    .w_data_i  (tbl_w_data_i),
    .r_cfg_i   (id_q),
    .r_field_i (field_q),
    .r_data_o  (rd_data)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_cfg_idle;
      id_q    <= '0;
      mask_q  <= '0;
      field_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      mask_q  <= mask_d;
      field_q <= field_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    mask_d        = mask_q;
    field_d       = field_q;
    tbl_w_ready_o = 1'b0;
    req_ready_o   = 1'b0;
    cfg_v_o       = '0;
    cfg_field_o   = '0;
    cfg_data_o    = '0;
    commit_v_o    = '0;
    err_o         = 1'b0;

    unique case (state_q)
      e_cfg_idle: begin
        tbl_w_ready_o = 1'b1;
        req_ready_o   = 1'b1;
        if (req_v_i) begin
          if (req_bad) begin
            state_d = e_cfg_err;
          end else begin
            id_d    = req_id_i;
            mask_d  = req_mask_i;
            field_d = '0;
            state_d = e_cfg_stream;
          end
        end
      end
      e_cfg_stream: begin
        cfg_v_o     = mask_q;
        cfg_field_o = field_q;
        cfg_data_o  = rd_data;
        // Only targeted channels gate progress; the final beat hands off to COMMIT.
        if ((cfg_ready_i & mask_q) == mask_q) begin
          if (32'(field_q) == fields_p - 1) begin
            state_d = e_cfg_commit;
          end else begin
            field_d = field_q + 1'b1;
          end
        end
      end
      e_cfg_commit: begin
        commit_v_o = mask_q;
        state_d    = e_cfg_idle;
      end
      e_cfg_err: begin
        err_o   = 1'b1;
        state_d = e_cfg_idle;
      end
      default: state_d = e_cfg_idle;
    endcase
  end

endmodule
